// File: rtl/store_write_buffer.sv
// store_write_buffer: in-order store queue with same-cycle load forwarding in front of Data_Memory
module store_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st_valid,
  input  logic [AW-1:0]              st_addr,
  input  logic [DW-1:0]              st_data,
  output logic                       st_ready,
  input  logic                       ld_valid,
  input  logic [AW-1:0]              ld_addr,
  output logic [DW-1:0]              ld_data,
  output logic                       ld_hit,
  output logic [AW-1:0]              mem_addr,
  output logic [DW-1:0]              mem_wdata,
  output logic                       mem_write,
  output logic                       mem_read,
  input  logic [DW-1:0]              mem_rdata,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    head, tail, idx;
  logic             push, drain, hit, ld_en;
  logic [DW-1:0]    fwd;

  assign ld_en    = ld_valid && !rst;
  assign st_ready = count < CW'(DEPTH);
  assign empty    = count == '0;
  assign push     = st_valid && st_ready;

  // Walk entries oldest to youngest so the last match seen is the youngest one
  always_comb begin
    hit = 1'b0;
    fwd = '0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (valid[idx] && addr_q[idx] == ld_addr) begin
        hit = 1'b1;
        fwd = data_q[idx];
      end
    end
  end

  // A load miss owns the memory port; otherwise the head entry drains
  always_comb begin
    ld_hit    = ld_en && hit;
    mem_read  = ld_en && !hit;
    ld_data   = !ld_en ? '0 : hit ? fwd : mem_rdata;
    drain     = !mem_read && !empty;
    mem_write = drain;
    mem_addr  = mem_read ? ld_addr : drain ? addr_q[head] : '0;
    mem_wdata = drain ? data_q[head] : '0;
  end

  // Pointer, occupancy and valid tracking; reset discards every pending store
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (push) begin
        valid[tail] <= 1'b1;
        tail        <= tail + 1'b1;
      end
      if (drain) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      count <= count + CW'(push) - CW'(drain);
    end
  end

  // Entry payload storage; contents are meaningless unless the valid bit is set
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= st_addr;
      data_q[tail] <= st_data;
    end
  end
endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- FIFO store buffer between the CPU datapath (ALU address / register-file store data) and Data_Memory.
- Stores are accepted in one cycle, queued, and drained into Data_Memory in program order, one per cycle, whenever the memory port is free.
- Loads are serviced the same cycle: forwarded from the youngest matching buffered store, otherwise read from Data_Memory. Data_Memory reads are combinational; writes commit on posedge.

Parameters:
DEPTH, 4, number of buffered stores; power of two, >=2
AW, 16, address width
DW, 16, data width

Ports:
clk  in  1  system clock, all state updates on posedge
rst  in  1  asynchronous, active-high reset
st_valid  in  1  store request this cycle
st_addr  in  AW  store word address
st_data  in  DW  store data
st_ready  out  1  buffer can accept a store (count < DEPTH)
ld_valid  in  1  load request this cycle
ld_addr  in  AW  load word address
ld_data  out  DW  load result, combinational, same cycle
ld_hit  out  1  ld_data was forwarded from the buffer
mem_addr  out  AW  to Data_Memory DMem_In
mem_wdata  out  DW  to Data_Memory Data_Write
mem_write  out  1  to Data_Memory Mem_Write
mem_read  out  1  to Data_Memory Mem_Read
mem_rdata  in  DW  from Data_Memory DataM_out
empty  out  1  count == 0; used as store fence
count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (async, immediate): count=0, head/tail pointers=0, all entries invalid. Outputs: empty=1, st_ready=1, mem_write=0, mem_read=0, mem_addr=0, mem_wdata=0, ld_hit=0, ld_data=0.
- Push: st_valid && st_ready captures {st_addr, st_data} at tail on posedge; tail wraps modulo DEPTH.
  - st_valid while full is ignored. No state change; the requester holds.
- Load lookup (combinational): compare ld_addr against all valid entries; the youngest match (closest to tail) wins.
  - Hit: ld_hit=1, ld_data=entry data, mem_read=0.
  - Miss: ld_hit=0, mem_read=1, mem_addr=ld_addr, ld_data=mem_rdata.
  - ld_valid=0: ld_hit=0, ld_data=0, mem_read=0.
- Memory port arbitration, per cycle:
  - A load miss owns the port: mem_write=0 and the drain stalls.
  - Otherwise, if count>0: mem_write=1, mem_addr/mem_wdata = head entry. Data_Memory commits at posedge, and the head pops on that same posedge (head wraps modulo DEPTH).
  - Otherwise: mem_write=0, mem_addr=0, mem_wdata=0.
- Push and pop on the same edge: count unchanged. Push when full with a pop that cycle is still refused (st_ready is based on current count only).
- Forwarding sees only entries already buffered. The store presented in the same cycle is not visible to a same-cycle load. With st_valid and ld_valid both high, the load is serviced against pre-push contents and the store is still accepted.
- Forwarding covers entries up to and including the head being drained that cycle.
- Word granularity only; no byte enables. Duplicate addresses may coexist and drain in order, so the last write wins in memory.
- Reset mid-drain: pending stores are discarded and the in-flight mem_write drops immediately. No write occurs on the reset-asserted edge.
- Latency: a store reaches memory 1..N cycles after acceptance (N = count ahead of it + 1 + stalled load-miss cycles).

Test Plan:
1. Reset, then push 0x0004=ABCD, 0x0006=5678, 0xFFFE=1234 on consecutive cycles, no loads -> mem_write high 3 cycles with those addr/data pairs in order; empty=1 afterward; reading 0xFFFE then returns 1234 via mem_rdata.
2. Hold ld_valid on miss address 0x0100 every cycle and push 5 stores -> st_ready=0 after the 4th, 5th ignored, count=4, mem_write=0 throughout, mem_read=1.
3. Stores 0x0004=1111 then 0x0004=2222 buffered; load 0x0004 -> ld_hit=1, ld_data=2222, mem_read=0, head (1111) drains the same cycle.
4. Buffer holds 0x0004 only; load 0x0008 with mem_rdata=BEEF -> ld_hit=0, mem_read=1, mem_addr=0x0008, ld_data=BEEF, no drain that cycle, count unchanged.
5. count=2, push a store while draining -> count stays 2, new entry lands at the correct tail across the wrap boundary (tail DEPTH-1 -> 0).
6. Assert rst asynchronously mid-cycle with count=3 and mem_write=1 -> mem_write=0, count=0, empty=1 before the next edge; the dropped stores never appear at Data_Memory.
